// File: rtl/clk_div_cfg.sv
// Ratio-change controller for a downstream clock divider. It gates the divider
// enable, lets the current half-period drain, swaps the ratio, then waits to settle.
module clk_div_cfg #(
  parameter int unsigned DEFAULT_RATIO = 1,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       i_ref_clk,
  input  logic       i_rst_n,
  input  logic       i_sys_en,
  input  logic       i_cfg_valid,
  input  logic [4:0] i_cfg_ratio,
  output logic       o_cfg_ready,
  output logic       o_cfg_done,
  output logic       o_cfg_err,
  output logic [4:0] o_div_ratio,
  output logic       o_clk_en
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_DRAIN  = 3'd2,
    S_LOAD   = 3'd3,
    S_SETTLE = 3'd4
  } state_t;

  localparam logic [4:0] LP_DEFAULT = 5'(DEFAULT_RATIO);
  localparam logic [4:0] LP_SETTLE  = 5'(SETTLE_CYCLES);

  state_t     r_state, w_state_next;
  logic [4:0] r_cnt, w_cnt_next;
  logic [4:0] r_pend, w_pend_next;

  logic       r_cfg_ready, r_cfg_done, r_cfg_err, r_clk_en;
  logic [4:0] r_div_ratio;
  logic       w_cfg_ready_next, w_cfg_done_next, w_cfg_err_next, w_clk_en_next;
  logic [4:0] w_div_ratio_next;

  logic w_accept, w_req_zero, w_req_same, w_req_load, w_cnt_last;

  // Ready is high exactly in IDLE/RUN, so a handshake can only happen there.
  assign w_accept   = i_cfg_valid && r_cfg_ready;
  assign w_req_zero = w_accept && (i_cfg_ratio == 5'd0);
  assign w_req_same = w_accept && !w_req_zero && (i_cfg_ratio == r_div_ratio);
  assign w_req_load = w_accept && !w_req_zero && !w_req_same;
  assign w_cnt_last = (r_cnt <= 5'd1);

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_pend  <= LP_DEFAULT;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_pend  <= w_pend_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pend_next  = r_pend;
    case (r_state)
      S_IDLE, S_RUN: begin
        if (w_req_load) begin
          w_state_next = S_DRAIN;
          w_pend_next  = i_cfg_ratio;
          w_cnt_next   = (r_div_ratio == 5'd0) ? 5'd1 : r_div_ratio;
        end else if (!w_accept) begin
          // A handshake (even a rejected or no-op one) holds the run state that edge.
          w_state_next = i_sys_en ? S_RUN : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (w_cnt_last) begin
          w_state_next = S_LOAD;
          w_cnt_next   = 5'd0;
        end else begin
          w_cnt_next = r_cnt - 5'd1;
        end
      end
      S_LOAD: begin
        w_state_next = S_SETTLE;
        w_cnt_next   = LP_SETTLE;
      end
      S_SETTLE: begin
        if (w_cnt_last) begin
          w_state_next = i_sys_en ? S_RUN : S_IDLE;
          w_cnt_next   = 5'd0;
        end else begin
          w_cnt_next = r_cnt - 5'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 5'd0;
      end
    endcase
  end

  always_comb begin
    w_clk_en_next    = (w_state_next == S_RUN);
    w_cfg_ready_next = (w_state_next == S_RUN) || (w_state_next == S_IDLE);
    w_cfg_err_next   = w_req_zero;
    w_cfg_done_next  = w_req_same || ((r_state == S_SETTLE) && w_cnt_last);
    w_div_ratio_next = (r_state == S_LOAD) ? r_pend : r_div_ratio;
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cfg_ready <= 1'b1;
      r_cfg_done  <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_clk_en    <= 1'b0;
      r_div_ratio <= LP_DEFAULT;
    end else begin
      r_cfg_ready <= w_cfg_ready_next;
      r_cfg_done  <= w_cfg_done_next;
      r_cfg_err   <= w_cfg_err_next;
      r_clk_en    <= w_clk_en_next;
      r_div_ratio <= w_div_ratio_next;
    end
  end

  assign o_cfg_ready = r_cfg_ready;
  assign o_cfg_done  = r_cfg_done;
  assign o_cfg_err   = r_cfg_err;
  assign o_clk_en    = r_clk_en;
  assign o_div_ratio = r_div_ratio;

endmodule

// File: tb/tb_clk_div_cfg.sv
// Bench for clk_div_cfg: directed vector table, hand-written corner sequences and
// random traffic checked against a schedule-based reference model.
module tb_clk_div_cfg;

  localparam int         S_CYC = 4;
  localparam logic [4:0] DEF   = 5'd1;

  logic       i_ref_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_sys_en = 1'b0;
  logic       i_cfg_valid = 1'b0;
  logic [4:0] i_cfg_ratio = 5'd0;
  logic       o_cfg_ready, o_cfg_done, o_cfg_err, o_clk_en;
  logic [4:0] o_div_ratio;

  always #5 i_ref_clk = ~i_ref_clk;

  clk_div_cfg #(.DEFAULT_RATIO(1), .SETTLE_CYCLES(S_CYC)) dut (
    .i_ref_clk  (i_ref_clk),
    .i_rst_n    (i_rst_n),
    .i_sys_en   (i_sys_en),
    .i_cfg_valid(i_cfg_valid),
    .i_cfg_ratio(i_cfg_ratio),
    .o_cfg_ready(o_cfg_ready),
    .o_cfg_done (o_cfg_done),
    .o_cfg_err  (o_cfg_err),
    .o_div_ratio(o_div_ratio),
    .o_clk_en   (o_clk_en)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a ratio change is a scheduled window measured in edges.
  bit         m_run, m_busy, m_done, m_err;
  logic [4:0] m_ratio, m_pend;
  int         m_edge, m_load_edge, m_end_edge;

  typedef struct {
    logic       se;
    logic       v;
    logic [4:0] r;
    logic       clk_en;
    logic [4:0] ratio;
    logic       ready;
    logic       done;
    logic       err;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_busy = 0; m_done = 0; m_err = 0;
    m_ratio = DEF; m_pend = DEF;
    m_edge = 0; m_load_edge = 0; m_end_edge = 0;
  endtask

  task automatic model_edge(input logic se, input logic v, input logic [4:0] r);
    m_edge++;
    m_done = 0;
    m_err  = 0;
    if (m_busy) begin
      if (m_edge == m_load_edge) m_ratio = m_pend;
      if (m_edge == m_end_edge) begin
        m_busy = 0;
        m_done = 1;
        m_run  = se;
      end
    end else if (v) begin
      if (r == 5'd0) m_err = 1;
      else if (r == m_ratio) m_done = 1;
      else begin
        m_busy      = 1;
        m_pend      = r;
        m_load_edge = m_edge + int'(m_ratio) + 1;
        m_end_edge  = m_load_edge + S_CYC;
      end
    end else begin
      m_run = se;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".clk_en"}, 32'(o_clk_en),    32'(m_run && !m_busy));
    chk({tag, ".ready"},  32'(o_cfg_ready), 32'(!m_busy));
    chk({tag, ".done"},   32'(o_cfg_done),  32'(m_done));
    chk({tag, ".err"},    32'(o_cfg_err),   32'(m_err));
    chk({tag, ".ratio"},  32'(o_div_ratio), 32'(m_ratio));
  endtask

  // Called at a negedge; drives inputs, lets one rising edge pass, returns at the next negedge.
  task automatic step(input logic se, input logic v, input logic [4:0] r);
    i_sys_en = se; i_cfg_valid = v; i_cfg_ratio = r;
    @(posedge i_ref_clk);
    model_edge(se, v, r);
    @(negedge i_ref_clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n_hold, n_set, cyc;
    logic       se_r, v_r;
    logic [4:0] r_r;

    tbl[0]  = '{1, 0, 5'd0, 1, 5'd1, 1, 0, 0};
    tbl[1]  = '{1, 1, 5'd8, 0, 5'd1, 0, 0, 0};
    tbl[2]  = '{1, 0, 5'd0, 0, 5'd1, 0, 0, 0};
    tbl[3]  = '{1, 0, 5'd0, 0, 5'd8, 0, 0, 0};
    tbl[4]  = '{1, 0, 5'd0, 0, 5'd8, 0, 0, 0};
    tbl[5]  = '{1, 0, 5'd0, 0, 5'd8, 0, 0, 0};
    tbl[6]  = '{1, 0, 5'd0, 0, 5'd8, 0, 0, 0};
    tbl[7]  = '{1, 0, 5'd0, 1, 5'd8, 1, 1, 0};
    tbl[8]  = '{1, 1, 5'd0, 1, 5'd8, 1, 0, 1};
    tbl[9]  = '{1, 1, 5'd8, 1, 5'd8, 1, 1, 0};
    tbl[10] = '{0, 0, 5'd0, 0, 5'd8, 1, 0, 0};
    tbl[11] = '{1, 0, 5'd0, 1, 5'd8, 1, 0, 0};

    model_reset();
    repeat (2) @(negedge i_ref_clk);
    chk("rst.clk_en", 32'(o_clk_en), 0);
    chk("rst.ready",  32'(o_cfg_ready), 1);
    chk("rst.done",   32'(o_cfg_done), 0);
    chk("rst.err",    32'(o_cfg_err), 0);
    chk("rst.ratio",  32'(o_div_ratio), 32'(DEF));
    i_rst_n = 1'b1;

    for (int k = 0; k < 12; k++) begin
      step(tbl[k].se, tbl[k].v, tbl[k].r);
      chk($sformatf("tbl%0d.clk_en", k), 32'(o_clk_en),    32'(tbl[k].clk_en));
      chk($sformatf("tbl%0d.ratio", k),  32'(o_div_ratio), 32'(tbl[k].ratio));
      chk($sformatf("tbl%0d.ready", k),  32'(o_cfg_ready), 32'(tbl[k].ready));
      chk($sformatf("tbl%0d.done", k),   32'(o_cfg_done),  32'(tbl[k].done));
      chk($sformatf("tbl%0d.err", k),    32'(o_cfg_err),   32'(tbl[k].err));
    end

    // Ratio 8 -> 3: eight drain cycles plus load, then four settle cycles.
    step(1, 1, 5'd3);
    check_model("r8to3");
    n_hold = 0; n_set = 0; cyc = 0;
    while (!o_cfg_ready && cyc < 60) begin
      if (o_div_ratio == 5'd8) n_hold++; else n_set++;
      step(1, 0, 5'd0);
      check_model("r8to3");
      cyc++;
    end
    chk("r8to3.ready_seen", 32'(o_cfg_ready), 1);
    chk("r8to3.drain_load", 32'(n_hold), 9);
    chk("r8to3.settle",     32'(n_set), 4);
    chk("r8to3.done",       32'(o_cfg_done), 1);
    chk("r8to3.clk_en",     32'(o_clk_en), 1);

    // Second request during drain ignored; i_sys_en dropped mid-sequence ends in IDLE.
    step(1, 1, 5'd5);
    check_model("drop");
    step(1, 1, 5'd7);
    check_model("drop");
    cyc = 0;
    while (!o_cfg_ready && cyc < 60) begin
      step((cyc < 2) ? 1'b1 : 1'b0, 0, 5'd0);
      check_model("drop");
      cyc++;
    end
    chk("drop.ratio",  32'(o_div_ratio), 5);
    chk("drop.clk_en", 32'(o_clk_en), 0);
    chk("drop.done",   32'(o_cfg_done), 1);
    step(0, 0, 5'd0);
    check_model("drop_idle");

    // Asynchronous reset during drain.
    step(1, 0, 5'd0);
    step(1, 1, 5'd9);
    step(1, 0, 5'd0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst.ratio",  32'(o_div_ratio), 32'(DEF));
    chk("arst.clk_en", 32'(o_clk_en), 0);
    chk("arst.ready",  32'(o_cfg_ready), 1);
    chk("arst.done",   32'(o_cfg_done), 0);
    model_reset();
    @(negedge i_ref_clk);
    i_rst_n = 1'b1;
    check_model("arst_hold");

    // Random traffic against the model.
    se_r = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) se_r = ~se_r;
      v_r = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0:       r_r = 5'd0;
        1:       r_r = m_ratio;
        default: r_r = 5'($urandom_range(1, 31));
      endcase
      step(se_r, v_r, r_r);
      check_model("rand");
      chk("rand.done_err_excl", 32'(o_cfg_done && o_cfg_err), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_div_cfg.md
CLK_DIV_CFG -- requirements
Module: clk_div_cfg

Interface
REQ-001 The block SHALL have parameter DEFAULT_RATIO, default 1, which is the divide ratio loaded at reset (5-bit, 1..31).
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 4, which is the number of gated cycles after a ratio load (1..15).
REQ-003 Port i_ref_clk SHALL be an input, 1 bit: reference clock; all logic runs on its rising edge.
REQ-004 Port i_rst_n SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-005 Port i_sys_en SHALL be an input, 1 bit: system request for the divided clock to run.
REQ-006 Port i_cfg_valid SHALL be an input, 1 bit: a configuration request is present.
REQ-007 Port i_cfg_ratio SHALL be an input, 5 bits: the requested divide ratio.
REQ-008 Port o_cfg_ready SHALL be an output, 1 bit: the block can accept a request this cycle.
REQ-009 Port o_cfg_done SHALL be an output, 1 bit: one-cycle pulse when a request completes.
REQ-010 Port o_cfg_err SHALL be an output, 1 bit: one-cycle pulse when a request is rejected.
REQ-011 Port o_div_ratio SHALL be an output, 5 bits: the ratio driven to the downstream divider's ratio input.
REQ-012 Port o_clk_en SHALL be an output, 1 bit: the enable driven to the downstream divider's clock-enable input.
REQ-013 All outputs SHALL be registered.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DRAIN, LOAD and SETTLE.
REQ-015 o_cfg_ready SHALL be 1 in IDLE and RUN and 0 in DRAIN, LOAD and SETTLE; a request is accepted only when i_cfg_valid and o_cfg_ready are both 1 on the same edge.
REQ-016 Request while ready, i_cfg_ratio = 0: the block SHALL reject it, pulse o_cfg_err for one cycle, and leave the state and o_div_ratio unchanged.
REQ-017 Request while ready, i_cfg_ratio = o_div_ratio: the block SHALL accept it, pulse o_cfg_done on the next cycle, and make no state change and no o_clk_en change.
REQ-018 Any other accepted request (ratio 1..31): the block SHALL latch it as the pending ratio, go to DRAIN, and drive o_clk_en = 0 from the next cycle.
REQ-019 DRAIN: o_clk_en SHALL stay 0 for exactly max(o_div_ratio, 1) cycles, using a down-counter loaded with the current ratio, so that an in-flight divided half-period completes.
REQ-020 LOAD: the block SHALL stay one cycle; o_div_ratio SHALL take the pending ratio at the end of LOAD; o_clk_en SHALL stay 0.
REQ-021 SETTLE: the block SHALL stay exactly SETTLE_CYCLES cycles with o_clk_en = 0, then pulse o_cfg_done for one cycle coinciding with the exit.
REQ-022 SETTLE exit SHALL go to RUN if i_sys_en = 1 at that edge, else to IDLE.
REQ-023 RUN SHALL drive o_clk_en = 1; when i_sys_en = 0 it SHALL go to IDLE and drive o_clk_en = 0 on the next cycle.
REQ-024 IDLE SHALL drive o_clk_en = 0; when i_sys_en = 1 it SHALL go to RUN and drive o_clk_en = 1 on the next cycle.
REQ-025 If i_sys_en changes during DRAIN, LOAD or SETTLE, the sequence SHALL NOT be aborted; i_sys_en is sampled only at SETTLE exit.
REQ-026 i_cfg_valid while o_cfg_ready = 0 SHALL be ignored: no error, no queuing.
REQ-027 Simultaneous accepted request and i_sys_en toggle in RUN/IDLE: the request SHALL take priority (go to DRAIN); the final state follows REQ-022.
REQ-028 o_cfg_done and o_cfg_err SHALL never be 1 in the same cycle.
REQ-029 o_div_ratio SHALL change only at the end of LOAD.
REQ-030 o_clk_en SHALL be 0 for at least max(old ratio, 1) + 1 + SETTLE_CYCLES cycles around every ratio change.

Reset
REQ-031 While i_rst_n = 0, the block SHALL be in IDLE with o_div_ratio = DEFAULT_RATIO, o_clk_en = 0, o_cfg_ready = 1, o_cfg_done = 0, o_cfg_err = 0, counter = 0, and pending ratio = DEFAULT_RATIO.
REQ-032 Reset asserted mid-sequence (any state) SHALL force REQ-031 values immediately, independent of the clock, and discard the pending request.
REQ-033 After deassertion, the first state change SHALL occur on the first rising edge of i_ref_clk.

Verification
REQ-034 Reset, then i_sys_en = 1 -> o_clk_en = 1 one cycle later, o_div_ratio = 1.
REQ-035 In RUN with ratio 1, request ratio 8 -> o_clk_en 0 next cycle; DRAIN 1 cycle, LOAD 1, SETTLE 4; o_div_ratio = 8 after LOAD; o_cfg_done pulse; o_clk_en = 1 the cycle after SETTLE exit.
REQ-036 Ratio 8 active, request ratio 3 -> DRAIN lasts 8 cycles, then o_div_ratio = 3, and o_clk_en returns 1 after 4 SETTLE cycles.
REQ-037 Request ratio 0 -> one-cycle o_cfg_err, o_div_ratio unchanged, o_clk_en unchanged; request equal to the current ratio -> o_cfg_done only.
REQ-038 i_sys_en dropped during SETTLE, plus a second i_cfg_valid during DRAIN -> the second request is ignored and the block ends in IDLE with o_clk_en = 0 and the new ratio loaded.
REQ-039 i_rst_n pulsed low during DRAIN -> o_div_ratio = DEFAULT_RATIO, o_clk_en = 0, o_cfg_ready = 1 immediately.
